sti_rx_deserializer: RTL and testbench
======================================

Name: sti_rx_deserializer

Overview:
- Serial-to-parallel receiver for the serial transmit interface: it is the receiving end of the so_data/so_valid stream.
- It collects one framed serial word of 8/16/24/32 bits and undoes bit-order reversal and fill/padding according to the latched frame configuration.
- It outputs the recovered 16-bit payload with a one-cycle valid strobe and error flags.
- It sits in loopback/verification paths and in downstream blocks that consume the transmitter's stream.

Parameters:
- CNT_W, 8, width of the received-word counter rx_count (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_load  input  1  pulse; latch cfg_* fields (honoured only in IDLE)
- cfg_length  input  2  00=8b, 01=16b, 10=24b, 11=32b frame
- cfg_msb  input  1  1 = frame sent MSB-first; 0 = LSB-first (bit-reversed)
- cfg_low  input  1  8-bit frames only: 1 = payload belongs in upper byte
- cfg_fill  input  1  24/32-bit only: 1 = payload in upper bits, zero pad low; 0 = payload in low 16, zero pad high
- si_data  input  1  serial data bit
- si_valid  input  1  qualifies si_data; high for every bit of a frame
- rx_data  output  16  recovered payload
- rx_valid  output  1  one-cycle strobe; rx_data/rx_pad_err valid
- rx_pad_err  output  1  pad bits of the completed frame were non-zero
- rx_frame_err  output  1  one-cycle strobe: si_valid dropped mid-frame
- rx_count  output  CNT_W  number of good frames received
- rx_busy  output  1  high while in RECV

Behaviour:
- Reset: state=IDLE; rx_data=0, rx_valid=0, rx_pad_err=0, rx_frame_err=0, rx_count=0, rx_busy=0; cfg registers = 0 (8-bit, LSB-first, low=0, fill=0); shift register and bit counter = 0. Reset mid-frame discards the partial frame, with no strobe.
- Frame length N = 8,16,24,32 from the latched cfg_length.
- The bit counter counts received bits 0..N-1.
- States:
  - IDLE: cfg_load latches cfg. On si_valid=1, capture the bit as first bit, bit count=1, go to RECV. If cfg_load and si_valid occur in the same cycle, the new cfg applies to this frame.
  - RECV: each si_valid=1 cycle shifts si_data into T (T = {T[30:0], si_data}); first-received bit ends at T[N-1]. On capture of bit N, go to DONE. If si_valid=0 before bit N, pulse rx_frame_err next cycle, discard the frame, go to IDLE. cfg_load in RECV is ignored.
  - DONE (1 cycle): register outputs; rx_valid=1; rx_count++. If si_valid=1 in this cycle, that bit is the first bit of the next frame (count=1, go to RECV, cfg unchanged); else go to IDLE.
- Output latency: rx_valid is asserted in the cycle after the last bit is sampled.
- Logical word L[N-1:0]:
  - cfg_msb=1: L = T[N-1:0].
  - cfg_msb=0: L = T[N-1:0] bit-reversed over N bits.
- Extraction to rx_data (other bits 0):
  - N=8: cfg_low=0 → {8'h00,L[7:0]}; cfg_low=1 → {L[7:0],8'h00}.
  - N=16: L[15:0].
  - N=24: fill=1 → L[23:8], pad L[7:0]; fill=0 → L[15:0], pad L[23:16].
  - N=32: fill=1 → L[31:16], pad L[15:0]; fill=0 → L[15:0], pad L[31:16].
- Pad error: rx_pad_err = OR of pad bits. It is valid with rx_valid. The frame still counts and rx_data is still delivered.
- Hold behaviour: rx_data and rx_pad_err hold between strobes. rx_valid and rx_frame_err are single-cycle pulses.
- rx_count wraps from 2^CNT_W-1 to 0. Frame errors do not increment rx_count.

Decomposition:
- Shared package:
  - length encodings LEN_8/16/24/32.
  - State enum IDLE/RECV/DONE.
  - Function len_bits(cfg_length) returning N.
  - Function bitrev32.
- One sub-module is natural: sti_rx_unpack (combinational T+cfg → rx_data, pad_err). The FSM, shifter and counters stay in the top.

Test Plan:
- len=16, msb=1: send 0xA5C3 MSB-first, 16 contiguous bits → next cycle rx_valid=1, rx_data=0xA5C3, pad_err=0, rx_count=1.
- len=8, msb=0, low=1: send 0x5A LSB-first (bits 0,1,0,1,1,0,1,0) → rx_data=0x5A00.
- len=24, msb=1, fill=1: send 0x123400 → rx_data=0x1234, pad_err=0. Then send 0x123401 → rx_data=0x1234, pad_err=1, rx_count=2.
- len=32, msb=0, fill=0: send L=0x0000BEEF LSB-first → rx_data=0xBEEF. Then drop si_valid after 20 bits of the next frame → one rx_frame_err pulse, no rx_valid, rx_count unchanged.
- Back-to-back frames:
  - Two 8-bit frames 0x81, 0x7E with si_valid continuously high for 16 cycles → two rx_valid pulses 8 cycles apart, with data 0x0081 then 0x007E.
  - cfg_load pulsed mid-frame is ignored.
- Reset asserted at bit 10 of a 16-bit frame → all outputs 0. Then send a fresh 8-bit 0xFF with default cfg → rx_data=0x00FF. Run 256 good frames → rx_count wraps to 0.

Source files
------------

// File: rtl/sti_rx_deserializer_pkg.sv
// Shared encodings, state type and helpers for the STI serial receiver.
package sti_rx_deserializer_pkg;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

    function automatic logic [5:0] len_bits(input logic [1:0] cfg_length);
        logic [5:0] n;
        case (cfg_length)
            LEN_8:   n = 6'd8;
            LEN_16:  n = 6'd16;
            LEN_24:  n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sti_rx_unpack.sv
// Combinational unpacking of a received serial word into the 16-bit payload
// and the pad-error flag, following the frame configuration.
module sti_rx_unpack
    import sti_rx_deserializer_pkg::*;
(
    input  logic [31:0] shreg,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    input  logic        cfg_fill,
    output logic [15:0] data,
    output logic        pad_err
);

    logic [31:0] rev_word;
    logic [31:0] lword;
    logic [5:0]  n_bits;

    assign n_bits = len_bits(cfg_length);

    always_comb begin
        // Reversing all 32 bits puts the N frame bits at the top; shift them back down.
        rev_word = bitrev32(shreg) >> (6'd32 - n_bits);
        lword    = cfg_msb ? shreg : rev_word;
        data     = 16'h0000;
        pad_err  = 1'b0;
        case (cfg_length)
            LEN_8: begin
                data = cfg_low ? {lword[7:0], 8'h00} : {8'h00, lword[7:0]};
            end
            LEN_16: begin
                data = lword[15:0];
            end
            LEN_24: begin
                if (cfg_fill) begin
                    data    = lword[23:8];
                    pad_err = |lword[7:0];
                end else begin
                    data    = lword[15:0];
                    pad_err = |lword[23:16];
                end
            end
            LEN_32: begin
                if (cfg_fill) begin
                    data    = lword[31:16];
                    pad_err = |lword[15:0];
                end else begin
                    data    = lword[15:0];
                    pad_err = |lword[31:16];
                end
            end
        endcase
    end

endmodule

// File: rtl/sti_rx_deserializer.sv
// STI serial receiver: collects one framed serial word, unpacks the payload
// and reports it with a one-cycle strobe plus pad/frame error flags.
module sti_rx_deserializer
    import sti_rx_deserializer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [1:0]       cfg_length,
    input  logic             cfg_msb,
    input  logic             cfg_low,
    input  logic             cfg_fill,
    input  logic             si_data,
    input  logic             si_valid,
    output logic [15:0]      rx_data,
    output logic             rx_valid,
    output logic             rx_pad_err,
    output logic             rx_frame_err,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_busy
);

    rx_state_e        state_q, state_d;
    logic [1:0]       cfg_length_q, cfg_length_d;
    logic             cfg_msb_q, cfg_msb_d;
    logic             cfg_low_q, cfg_low_d;
    logic             cfg_fill_q, cfg_fill_d;
    logic [30:0]      shreg_q, shreg_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_pad_err_q, rx_pad_err_d;
    logic             rx_frame_err_q, rx_frame_err_d;
    logic [CNT_W-1:0] rx_count_q, rx_count_d;
    logic             rx_busy_q, rx_busy_d;

    logic [31:0]      shreg_shift;
    logic [5:0]       bit_cnt_inc;
    logic [5:0]       frame_bits;
    logic [15:0]      unpack_data;
    logic             unpack_pad;

    // Bit 31 is never stored: a 32-bit frame completes on the shift that fills it.
    assign shreg_shift = {shreg_q, si_data};
    assign bit_cnt_inc = bit_cnt_q + 6'd1;
    assign frame_bits  = len_bits(cfg_length_q);

    sti_rx_unpack u_unpack (
        .shreg      (shreg_shift),
        .cfg_length (cfg_length_q),
        .cfg_msb    (cfg_msb_q),
        .cfg_low    (cfg_low_q),
        .cfg_fill   (cfg_fill_q),
        .data       (unpack_data),
        .pad_err    (unpack_pad)
    );

    always_comb begin
        state_d        = state_q;
        cfg_length_d   = cfg_length_q;
        cfg_msb_d      = cfg_msb_q;
        cfg_low_d      = cfg_low_q;
        cfg_fill_d     = cfg_fill_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        rx_data_d      = rx_data_q;
        rx_pad_err_d   = rx_pad_err_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
        rx_count_d     = rx_count_q;

        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    cfg_length_d = cfg_length;
                    cfg_msb_d    = cfg_msb;
                    cfg_low_d    = cfg_low;
                    cfg_fill_d   = cfg_fill;
                end
                if (si_valid) begin
                    shreg_d   = {30'd0, si_data};
                    bit_cnt_d = 6'd1;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (si_valid) begin
                    shreg_d   = shreg_shift[30:0];
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == frame_bits) begin
                        state_d      = DONE;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = unpack_data;
                        rx_pad_err_d = unpack_pad;
                        rx_count_d   = rx_count_q + 1'b1;
                    end
                end else begin
                    rx_frame_err_d = 1'b1;
                    bit_cnt_d      = 6'd0;
                    state_d        = IDLE;
                end
            end
            DONE: begin
                // A bit arriving here already belongs to the next frame.
                if (si_valid) begin
                    shreg_d   = {30'd0, si_data};
                    bit_cnt_d = 6'd1;
                    state_d   = RECV;
                end else begin
                    bit_cnt_d = 6'd0;
                    state_d   = IDLE;
                end
            end
            default: begin
                bit_cnt_d = 6'd0;
                state_d   = IDLE;
            end
        endcase

        rx_busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cfg_length_q   <= LEN_8;
            cfg_msb_q      <= 1'b0;
            cfg_low_q      <= 1'b0;
            cfg_fill_q     <= 1'b0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_pad_err_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_count_q     <= '0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_length_q   <= cfg_length_d;
            cfg_msb_q      <= cfg_msb_d;
            cfg_low_q      <= cfg_low_d;
            cfg_fill_q     <= cfg_fill_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_pad_err_q   <= rx_pad_err_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_count_q     <= rx_count_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_pad_err   = rx_pad_err_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_count     = rx_count_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_sti_rx_deserializer.sv
// Self-checking bench for sti_rx_deserializer: fixed vector table, directed
// multi-cycle sequences and randomized frames against a word-level model.
module tb_sti_rx_deserializer;

    logic        clk;
    logic        reset;
    logic        cfg_load;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_low;
    logic        cfg_fill;
    logic        si_data;
    logic        si_valid;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_pad_err;
    logic        rx_frame_err;
    logic [7:0]  rx_count;
    logic        rx_busy;

    sti_rx_deserializer #(.CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_load     (cfg_load),
        .cfg_length   (cfg_length),
        .cfg_msb      (cfg_msb),
        .cfg_low      (cfg_low),
        .cfg_fill     (cfg_fill),
        .si_data      (si_data),
        .si_valid     (si_valid),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pad_err   (rx_pad_err),
        .rx_frame_err (rx_frame_err),
        .rx_count     (rx_count),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    logic [7:0] exp_count;

    typedef struct {
        logic [1:0]  len;
        logic        msb;
        logic        low;
        logic        fill;
        logic [31:0] word;
        logic [15:0] exp_data;
        logic        exp_pad;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Payload rules written directly on the logical word.
    function automatic logic [16:0] model(input logic [31:0] word, input logic [1:0] len,
                                          input logic low, input logic fill);
        int unsigned n;
        logic [31:0] w;
        logic [15:0] d;
        logic        p;
        n = 8 * (int'(len) + 1);
        w = (n == 32) ? word : (word & ((32'd1 << n) - 32'd1));
        p = 1'b0;
        case (n)
            8:  d = low ? 16'((w & 32'hFF) << 8) : 16'(w);
            16: d = 16'(w);
            24: begin
                if (fill) begin d = 16'(w >> 8);  p = (w & 32'hFF) != 0; end
                else      begin d = 16'(w);       p = (w >> 16) != 0;    end
            end
            default: begin
                if (fill) begin d = 16'(w >> 16); p = (w & 32'hFFFF) != 0; end
                else      begin d = 16'(w);       p = (w >> 16) != 0;      end
            end
        endcase
        return {p, d};
    endfunction

    task automatic step_idle();
        @(negedge clk);
        si_valid = 1'b0;
        si_data  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic msb, input logic low, input logic fill);
        cfg_length = len;
        cfg_msb    = msb;
        cfg_low    = low;
        cfg_fill   = fill;
    endtask

    task automatic load_cfg(input logic [1:0] len, input logic msb, input logic low, input logic fill);
        @(negedge clk);
        set_cfg(len, msb, low, fill);
        cfg_load = 1'b1;
        si_valid = 1'b0;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Drives n bits in transmitter order; returns with the last bit still on the wire.
    task automatic drive_frame(input logic [31:0] word, input int n, input logic msb,
                               input logic load_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = msb ? word[n-1-i] : word[i];
            cfg_load = (i == 0) && load_first;
        end
    endtask

    task automatic finish_frame(input string name, input logic [15:0] ed, input logic ep,
                                input bit full);
        step_idle();
        exp_count = exp_count + 8'd1;
        chk({name, ".valid"}, rx_valid, 1);
        chk({name, ".data"}, rx_data, ed);
        chk({name, ".pad"}, rx_pad_err, ep);
        chk({name, ".count"}, rx_count, exp_count);
        step_idle();
        if (full) begin
            chk({name, ".valid_drop"}, rx_valid, 0);
            chk({name, ".data_hold"}, rx_data, ed);
            chk({name, ".busy"}, rx_busy, 0);
        end
    endtask

    initial begin
        int          pulse_pos[$];
        logic [15:0] pulse_data[$];
        logic [15:0] stream;
        logic [15:0] w16;
        logic [16:0] m;
        logic [1:0]  r_len;
        logic        r_msb, r_low, r_fill;
        logic [31:0] r_word;

        checks    = 0;
        errors    = 0;
        exp_count = 8'd0;

        vecs[0] = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 16'hA5C3, 1'b0};
        vecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 16'h5A00, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h00123400, 16'h1234, 1'b0};
        vecs[3] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h00123401, 16'h1234, 1'b1};
        vecs[4] = '{2'd3, 1'b0, 1'b0, 1'b0, 32'h0000BEEF, 16'hBEEF, 1'b0};
        vecs[5] = '{2'd3, 1'b1, 1'b0, 1'b1, 32'hCAFE0000, 16'hCAFE, 1'b0};
        vecs[6] = '{2'd3, 1'b0, 1'b0, 1'b1, 32'h12340001, 16'h1234, 1'b1};
        vecs[7] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h0001ABCD, 16'hABCD, 1'b1};
        vecs[8] = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h0000003C, 16'h003C, 1'b0};
        vecs[9] = '{2'd3, 1'b1, 1'b0, 1'b0, 32'h80007777, 16'h7777, 1'b1};

        reset    = 1'b1;
        cfg_load = 1'b0;
        set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
        si_data  = 1'b0;
        si_valid = 1'b0;
        #2;
        chk("reset.data", rx_data, 0);
        chk("reset.valid", rx_valid, 0);
        chk("reset.count", rx_count, 0);
        chk("reset.busy", rx_busy, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            load_cfg(vecs[v].len, vecs[v].msb, vecs[v].low, vecs[v].fill);
            drive_frame(vecs[v].word, 8 * (int'(vecs[v].len) + 1), vecs[v].msb, 1'b0);
            finish_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_pad, 1'b1);
        end

        // Good 32-bit frame, then a frame abandoned after 20 bits.
        load_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        drive_frame(32'h0000BEEF, 32, 1'b0, 1'b0);
        finish_frame("ferr_pre", 16'hBEEF, 1'b0, 1'b1);
        drive_frame(32'hFFFF1234, 20, 1'b0, 1'b0);
        step_idle();
        chk("ferr.busy_mid", rx_busy, 1);
        chk("ferr.early", rx_frame_err, 0);
        step_idle();
        chk("ferr.pulse", rx_frame_err, 1);
        chk("ferr.no_valid", rx_valid, 0);
        chk("ferr.count", rx_count, exp_count);
        chk("ferr.data_hold", rx_data, 16'hBEEF);
        step_idle();
        chk("ferr.drop", rx_frame_err, 0);
        chk("ferr.no_valid2", rx_valid, 0);

        // Two 8-bit frames with si_valid held high for 16 cycles.
        load_cfg(2'd0, 1'b1, 1'b0, 1'b0);
        stream = 16'h817E;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                pulse_pos.push_back(i);
                pulse_data.push_back(rx_data);
            end
            if (i < 16) begin
                si_valid = 1'b1;
                si_data  = stream[15-i];
            end else begin
                si_valid = 1'b0;
                si_data  = 1'b0;
            end
        end
        exp_count = exp_count + 8'd2;
        chk("b2b.pulses", pulse_pos.size(), 2);
        if (pulse_pos.size() == 2) begin
            chk("b2b.first_at", pulse_pos[0], 8);
            chk("b2b.spacing", pulse_pos[1] - pulse_pos[0], 8);
            chk("b2b.data0", pulse_data[0], 16'h0081);
            chk("b2b.data1", pulse_data[1], 16'h007E);
        end
        chk("b2b.count", rx_count, exp_count);
        step_idle();

        // cfg_load mid-frame must not disturb the running 16-bit frame or later ones.
        load_cfg(2'd1, 1'b1, 1'b0, 1'b0);
        w16 = 16'h1357;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = w16[15-i];
            cfg_load = (i == 5);
            if (i == 5) set_cfg(2'd0, 1'b0, 1'b1, 1'b1);
        end
        finish_frame("midcfg", 16'h1357, 1'b0, 1'b1);
        drive_frame(32'h00002468, 16, 1'b1, 1'b0);
        finish_frame("midcfg_next", 16'h2468, 1'b0, 1'b1);

        // Reset at bit 10 of a 16-bit frame.
        drive_frame(32'h0000F00D, 10, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_mid.busy", rx_busy, 1);
        reset    = 1'b1;
        si_valid = 1'b0;
        #1;
        chk("rst_mid.data", rx_data, 0);
        chk("rst_mid.count", rx_count, 0);
        chk("rst_mid.busy0", rx_busy, 0);
        chk("rst_mid.flags", {rx_valid, rx_pad_err, rx_frame_err}, 0);
        @(negedge clk);
        reset     = 1'b0;
        exp_count = 8'd0;
        drive_frame(32'h000000FF, 8, 1'b0, 1'b0);
        finish_frame("post_rst", 16'h00FF, 1'b0, 1'b1);

        // 255 random frames complete the 256 since reset.
        for (int f = 0; f < 255; f++) begin
            r_len  = 2'($urandom_range(0, 3));
            r_msb  = 1'($urandom_range(0, 1));
            r_low  = 1'($urandom_range(0, 1));
            r_fill = 1'($urandom_range(0, 1));
            r_word = $urandom;
            if ($urandom_range(0, 3) == 0) r_word = r_word & 32'h0000FFFF;
            m = model(r_word, r_len, r_low, r_fill);
            if ($urandom_range(0, 1) == 1) begin
                load_cfg(r_len, r_msb, r_low, r_fill);
                drive_frame(r_word, 8 * (int'(r_len) + 1), r_msb, 1'b0);
            end else begin
                set_cfg(r_len, r_msb, r_low, r_fill);
                drive_frame(r_word, 8 * (int'(r_len) + 1), r_msb, 1'b1);
            end
            finish_frame($sformatf("rand%0d", f), m[15:0], m[16], 1'b0);
        end
        chk("wrap.count", rx_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
